// File: rtl/uart_protocol.sv
// 8N1 UART: independent transmitter and receiver sharing clk, with a 2-flop
// synchronizer on the receive line. Bit timers are down-counters reloaded per bit.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for tx_start
//   TX_START | driving start bit (0)
//   TX_DATA  | driving data bits, LSB first
//   TX_STOP  | driving stop bit (1), tx_done on its last cycle
//   RX_IDLE  | waiting for synchronized line low
//   RX_START | timing to mid start bit to reject glitches
//   RX_DATA  | sampling 8 data bits mid-bit
//   RX_STOP  | sampling stop bit, commit byte if high
`timescale 1ns/1ps
module uart_protocol #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       rx_serial,
    output logic       tx_serial,
    output logic [7:0] rx_data,
    output logic       tx_done,
    output logic       rx_done
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic [2:0]       tx_idx, tx_idx_nxt;
    logic             tx_serial_nxt;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [2:0]       rx_idx, rx_idx_nxt;
    logic [7:0]       rx_data_nxt;
    logic             rx_done_nxt;
    logic             rx_meta, rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_shift  <= '0;
            tx_idx    <= '0;
            tx_serial <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_idx    <= tx_idx_nxt;
            tx_serial <= tx_serial_nxt;
        end
    end

    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_shift_nxt  = tx_shift;
        tx_idx_nxt    = tx_idx;
        tx_serial_nxt = tx_serial;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_serial_nxt = 1'b1;
                if (tx_start) begin
                    tx_shift_nxt  = tx_data;
                    tx_serial_nxt = 1'b0;
                    tx_cnt_nxt    = BIT_RELOAD;
                    tx_state_nxt  = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt    = BIT_RELOAD;
                    tx_idx_nxt    = '0;
                    tx_serial_nxt = tx_shift[0];
                    tx_state_nxt  = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = BIT_RELOAD;
                    if (tx_idx == 3'd7) begin
                        tx_serial_nxt = 1'b1;
                        tx_state_nxt  = TX_STOP;
                    end else begin
                        tx_idx_nxt    = tx_idx + 3'd1;
                        tx_serial_nxt = tx_shift[1];
                        tx_shift_nxt  = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_done       = 1'b1;
                    tx_serial_nxt = 1'b1;
                    tx_state_nxt  = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Synchronizer resets to the idle level so reset release never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_idx   <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_meta  <= rx_serial;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_shift <= rx_shift_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_data  <= rx_data_nxt;
            rx_done  <= rx_done_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_shift_nxt = rx_shift;
        rx_idx_nxt   = rx_idx;
        rx_data_nxt  = rx_data;
        rx_done_nxt  = rx_done;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_nxt   = HALF_RELOAD;
                    rx_done_nxt  = 1'b0;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_cnt_nxt   = BIT_RELOAD;
                        rx_idx_nxt   = '0;
                        rx_state_nxt = RX_DATA;
                    end else begin
                        rx_state_nxt = RX_IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_cnt_nxt   = BIT_RELOAD;
                    if (rx_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_data_nxt = rx_shift;
                        rx_done_nxt = 1'b1;
                    end
                    rx_state_nxt = RX_IDLE;
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_protocol.sv
// Bench for uart_protocol: elapsed-cycle reference model compared every cycle,
// directed loopback/timing/busy/glitch/framing cases, then randomized traffic.
`timescale 1ns/1ps
module tb_uart_protocol;
    localparam int CLOCK_FREQ = 1_600_000;
    localparam int BAUD       = 100_000;
    localparam int CPB        = CLOCK_FREQ / BAUD;
    localparam int HALF       = CPB / 2;
    localparam int FRAME      = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_serial;
    logic       tx_serial, tx_done, rx_done;
    logic [7:0] rx_data;

    logic loop_en  = 1'b1;
    logic line_drv = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cnt = 0;

    uart_protocol #(.BAUD_RATE(BAUD), .CLOCK_FREQ(CLOCK_FREQ)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .rx_serial(rx_serial), .tx_serial(tx_serial), .rx_data(rx_data),
        .tx_done(tx_done), .rx_done(rx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) rx_serial <= 1'b1;
        else     rx_serial <= loop_en ? tx_serial : line_drv;
    end

    // Reference model: transmitter as a timed 10-bit frame, receiver as sample instants
    logic       m_tx_busy = 1'b0, m_tx_ser = 1'b1, m_tx_done = 1'b0;
    int         m_tx_k = 0;
    logic [9:0] m_frame = '1;
    logic       m_rx_busy = 1'b0, m_rx_done = 1'b0;
    int         m_rx_t = 0, m_idx = 0;
    logic [7:0] m_bits = '0, m_rx_data = '0;
    logic       d1 = 1'b1, d2 = 1'b1, m_syn = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tx_busy = 1'b0; m_tx_k = 0; m_tx_ser = 1'b1; m_tx_done = 1'b0;
            m_rx_busy = 1'b0; m_rx_t = 0; m_rx_done = 1'b0; m_rx_data = '0;
            d1 = 1'b1; d2 = 1'b1;
        end else begin
            m_syn = d2; d2 = d1; d1 = rx_serial;
            if (!m_tx_busy) begin
                if (tx_start) begin
                    m_tx_busy = 1'b1; m_tx_k = 0; m_frame = {1'b1, tx_data, 1'b0};
                end
            end else if (m_tx_k == FRAME - 1) begin
                m_tx_busy = 1'b0;
            end else begin
                m_tx_k++;
            end
            m_tx_ser  = m_tx_busy ? m_frame[m_tx_k / CPB] : 1'b1;
            m_tx_done = m_tx_busy && (m_tx_k == FRAME - 1);

            if (!m_rx_busy) begin
                if (!m_syn) begin
                    m_rx_busy = 1'b1; m_rx_t = 0; m_rx_done = 1'b0;
                end
            end else begin
                m_rx_t++;
                if (m_rx_t == HALF) begin
                    if (m_syn) m_rx_busy = 1'b0;
                end else if (m_rx_t > HALF && (m_rx_t - HALF) % CPB == 0) begin
                    m_idx = (m_rx_t - HALF) / CPB;
                    if (m_idx <= 8) begin
                        m_bits[m_idx-1] = m_syn;
                    end else begin
                        if (m_syn) begin
                            m_rx_data = m_bits; m_rx_done = 1'b1;
                        end
                        m_rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: wait expired at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        check("tx_serial", tx_serial, m_tx_ser);
        check("tx_done", tx_done, m_tx_done);
        check("rx_done", rx_done, m_rx_done);
        check("rx_data", rx_data, m_rx_data);
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic wait_tx_idle();
        int n = 0;
        while (m_tx_busy && n < FRAME + 20) begin @(negedge clk); n++; end
        if (m_tx_busy) timeout("tx_idle");
    endtask

    task automatic wait_rx_idle();
        int n = 0;
        while (m_rx_busy && n < FRAME + 20) begin @(negedge clk); n++; end
        if (m_rx_busy) timeout("rx_idle");
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data = d; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_tx_done(output int lat);
        int n = 0;
        while (tx_done !== 1'b1 && n < FRAME + 20) begin @(negedge clk); n++; end
        if (tx_done !== 1'b1) timeout("tx_done");
        lat = cyc - acc_cyc;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); line_drv = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk); line_drv = 1'b1;
    endtask

    task automatic glitch(input int len);
        @(negedge clk); line_drv = 1'b0;
        repeat (len) @(negedge clk);
        line_drv = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, n, mode, len;
        logic [9:0] seq;
        logic [7:0] b;

        #100; @(negedge clk);
        check("rst_tx_serial", tx_serial, 1'b1);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;

        send(8'hAA);
        wait_tx_done(lat);
        check("aa_latency", lat, FRAME - 1);
        check("aa_rx_done", rx_done, 1'b1);
        check("aa_rx_data", rx_data, 8'hAA);

        send(8'h3C);
        n = 0;
        while (rx_done === 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("3c_rx_done_drop", rx_done, 1'b0);
        d0 = done_cnt;
        wait_tx_done(lat);
        check("3c_rx_done", rx_done, 1'b1);
        check("3c_rx_data", rx_data, 8'h3C);
        wait_tx_idle();
        check("3c_one_tx_done", done_cnt - d0, 1);

        send(8'h01);
        repeat (HALF) @(negedge clk);
        seq[0] = tx_serial;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            seq[i] = tx_serial;
        end
        check("bit_seq_01", seq, 10'h202);
        wait_tx_idle(); wait_rx_idle();

        d0 = done_cnt;
        send(8'h55);
        repeat (3 * CPB) @(negedge clk);
        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        wait_tx_idle(); wait_rx_idle();
        repeat (5) @(negedge clk);
        check("busy_one_done", done_cnt - d0, 1);
        check("busy_rx_data", rx_data, 8'h55);

        loop_en = 1'b0;
        glitch(HALF - 3);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_rx_done", rx_done, 1'b0);
        check("glitch_rx_data", rx_data, 8'h55);

        drive_frame(8'h12, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        wait_rx_idle();
        check("frame_err_rx_done", rx_done, 1'b0);
        check("frame_err_rx_data", rx_data, 8'h55);
        drive_frame(8'h12, 1'b1);
        wait_rx_idle();
        check("good_12_rx_done", rx_done, 1'b1);
        check("good_12_rx_data", rx_data, 8'h12);
        loop_en = 1'b1;

        d0 = done_cnt;
        send(8'h77);
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_serial", tx_serial, 1'b1);
        check("midrst_rx_data", rx_data, 8'h00);
        @(negedge clk); rst = 1'b0;
        repeat (FRAME) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);

        for (int it = 0; it < 24; it++) begin
            mode = int'($urandom_range(0, 3));
            b = 8'($urandom);
            case (mode)
                0: begin
                    send(b);
                    for (int s = 0; s < int'($urandom_range(0, 4)); s++) begin
                        repeat ($urandom_range(1, 20)) @(negedge clk);
                        tx_data = 8'($urandom); tx_start = 1'b1;
                        @(negedge clk); tx_start = 1'b0;
                    end
                end
                1: begin
                    @(negedge clk); tx_start = 1'b1;
                    for (int c = 0; c < 2 * FRAME + 5; c++) begin
                        if (c % 7 == 0) tx_data = 8'($urandom);
                        @(negedge clk);
                    end
                    tx_start = 1'b0;
                end
                2: begin
                    loop_en = 1'b0;
                    drive_frame(b, $urandom_range(0, 3) != 0);
                    repeat (2 * CPB) @(negedge clk);
                end
                default: begin
                    loop_en = 1'b0;
                    len = int'($urandom_range(1, HALF - 2));
                    glitch(len);
                    repeat (CPB) @(negedge clk);
                end
            endcase
            wait_tx_idle(); wait_rx_idle();
            repeat (3) @(negedge clk);
            wait_rx_idle();
            loop_en = 1'b1;
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
